// File: rtl/mc_control_unit.sv
// Control FSM, instruction latch and Z/C flag register for the multi-cycle core.
// Walks each instruction through FETCH/DECODE/EXECUTE/WRITEBACK and squashes conditional ops.
module mc_control_unit #(
  parameter int unsigned OPW    = 4,
  parameter int unsigned RAW    = 3,
  parameter int unsigned PC_INC = 1
) (
  input  logic           clk_i,
  input  logic           reset_i,
  input  logic [15:0]    instr_i,
  input  logic           alu_zero_i,
  input  logic           alu_carry_i,
  output logic [1:0]     state_o,
  output logic           ir_write_o,
  output logic           pc_write_o,
  output logic           reg_write_o,
  output logic           mem_write_o,
  output logic           mem_to_reg_o,
  output logic [1:0]     alu_op_o,
  output logic           alusrcb_o,
  output logic           comp_b_o,
  output logic [RAW-1:0] rf_wa_o,
  output logic           zero_o,
  output logic           carry_o,
  output logic           illegal_o
);

  typedef enum logic [1:0] {
    StFetch     = 2'b00,
    StDecode    = 2'b01,
    StExecute   = 2'b10,
    StWriteback = 2'b11
  } state_e;

  localparam logic [OPW-1:0] OpAdi  = OPW'(0);
  localparam logic [OPW-1:0] OpAdd  = OPW'(1);
  localparam logic [OPW-1:0] OpNand = OPW'(2);
  localparam logic [OPW-1:0] OpLhi  = OPW'(3);
  localparam logic [OPW-1:0] OpLw   = OPW'(4);
  localparam logic [OPW-1:0] OpSw   = OPW'(5);

  localparam logic [1:0] AluAdd  = 2'b00;
  localparam logic [1:0] AluNand = 2'b01;
  localparam logic [1:0] AluPass = 2'b10;

  state_e      state_q, state_d;
  logic [15:0] ir_q, ir_d;
  logic        zero_q, zero_d;
  logic        carry_q, carry_d;
  logic        cond_ok_q, cond_ok_d;

  // ---------------------------------------------------------------------------
  // Field decode of the latched instruction
  // ---------------------------------------------------------------------------
  logic [OPW-1:0] opcode;
  logic [1:0]     cz;
  logic           is_adi, is_add, is_nand, is_lhi, is_lw, is_sw;
  logic           is_rtype, legal, cond_ok;
  logic [RAW-1:0] wa;

  always_comb begin
    opcode   = ir_q[15 -: OPW];
    cz       = ir_q[1:0];
    is_adi   = (opcode == OpAdi);
    is_add   = (opcode == OpAdd);
    is_nand  = (opcode == OpNand);
    is_lhi   = (opcode == OpLhi);
    is_lw    = (opcode == OpLw);
    is_sw    = (opcode == OpSw);
    is_rtype = is_add | is_nand;
    legal    = (is_adi | is_add | is_nand | is_lhi | is_lw | is_sw) &
               ~(is_rtype & (cz == 2'b11));
    cond_ok  = (cz == 2'b00) | ((cz == 2'b10) & carry_q) | ((cz == 2'b01) & zero_q);
    wa       = '0;
    if (is_rtype) begin
      wa = ir_q[3 +: RAW];
    end else if (is_adi) begin
      wa = ir_q[6 +: RAW];
    end else if (is_lhi | is_lw) begin
      wa = ir_q[9 +: RAW];
    end
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= StFetch;
      ir_q      <= '0;
      zero_q    <= 1'b0;
      carry_q   <= 1'b0;
      cond_ok_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      zero_q    <= zero_d;
      carry_q   <= carry_d;
      cond_ok_q <= cond_ok_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    ir_d      = ir_q;
    zero_d    = zero_q;
    carry_d   = carry_q;
    cond_ok_d = cond_ok_q;
    unique case (state_q)
      StFetch: begin
        ir_d    = instr_i;
        state_d = StDecode;
      end
      StDecode: begin
        // Condition is sampled against the flags as they stand in DECODE.
        cond_ok_d = cond_ok;
        state_d   = legal ? StExecute : StFetch;
      end
      StExecute: begin
        state_d = (is_rtype && !cond_ok_q) ? StFetch : StWriteback;
      end
      StWriteback: begin
        if (is_add | is_adi | is_nand | is_lw) zero_d  = alu_zero_i;
        if (is_add | is_adi)                   carry_d = alu_carry_i;
        state_d = StFetch;
      end
      default: state_d = StFetch;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Moore outputs; forced low while reset is asserted so an abort is visible at once
  // ---------------------------------------------------------------------------
  always_comb begin
    ir_write_o   = 1'b0;
    pc_write_o   = 1'b0;
    reg_write_o  = 1'b0;
    mem_write_o  = 1'b0;
    mem_to_reg_o = 1'b0;
    alu_op_o     = AluAdd;
    alusrcb_o    = 1'b0;
    comp_b_o     = 1'b0;
    rf_wa_o      = '0;
    illegal_o    = 1'b0;
    if (!reset_i) begin
      unique case (state_q)
        StFetch: begin
          ir_write_o = 1'b1;
          pc_write_o = (PC_INC != 0);
        end
        StDecode: begin
          illegal_o = ~legal;
        end
        StExecute, StWriteback: begin
          alu_op_o  = is_nand ? AluNand : (is_lhi ? AluPass : AluAdd);
          alusrcb_o = is_adi | is_lw | is_sw;
          comp_b_o  = is_rtype & ir_q[2];
          rf_wa_o   = wa;
          if (state_q == StWriteback) begin
            reg_write_o  = ~is_sw;
            mem_write_o  = is_sw;
            mem_to_reg_o = is_lw;
          end
        end
        default: ;
      endcase
    end
  end

  assign state_o = state_q;
  assign zero_o  = zero_q;
  assign carry_o = carry_q;

endmodule
